// File: rtl/nn_pkg.sv
// Shared parameters, FSM encoding and accumulator-bus helper for the digit-inference path.
package nn_pkg;

    localparam int unsigned N_PIX     = 784;
    localparam int unsigned N_CLS     = 10;
    localparam int unsigned AW        = 10;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned MAC_LAT   = 1;
    localparam int unsigned DRAIN_CYC = RD_LAT + MAC_LAT;
    localparam int unsigned CW        = 4;
    localparam int unsigned SUM_W     = N_CLS * ACC_W;
    localparam int unsigned SEL_W     = $clog2(SUM_W);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        ARGMAX,
        DONE
    } state_t;

    // Class k signed sum out of the flattened accumulator bus.
    function automatic logic signed [ACC_W-1:0] acc_slice(input logic [SUM_W-1:0] sums,
                                                          input logic [CW-1:0]    k);
        logic [SEL_W-1:0] base;
        base = SEL_W'(k) * SEL_W'(ACC_W);
        return sums[base +: ACC_W];
    endfunction

endpackage

// File: rtl/nn_infer_sequencer_if.sv
// Control/result bus between the inference sequencer, the MAC datapath and the host.
interface nn_infer_sequencer_if;
    import nn_pkg::*;

    logic                    start;
    logic                    busy;
    logic                    done;
    logic [AW-1:0]           pix_addr;
    logic [AW-1:0]           w_addr;
    logic                    acc_clr;
    logic                    acc_en;
    logic [SUM_W-1:0]        acc_sum;
    logic [CW-1:0]           digit;
    logic signed [ACC_W-1:0] score;

    // Sequencer side.
    modport slave (
        input  start, acc_sum,
        output busy, done, pix_addr, w_addr, acc_clr, acc_en, digit, score
    );

    // Host / datapath side.
    modport master (
        output start, acc_sum,
        input  busy, done, pix_addr, w_addr, acc_clr, acc_en, digit, score
    );

endinterface

// File: rtl/nn_argmax_seq.sv
// Sequential argmax: tracks the best class index/value over one candidate per cycle.
module nn_argmax_seq
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    step,
    input  logic [CW-1:0]           idx,
    input  logic signed [ACC_W-1:0] value,
    output logic [CW-1:0]           best_idx_c,
    output logic signed [ACC_W-1:0] best_val_c
);

    logic [CW-1:0]           idx_q;
    logic signed [ACC_W-1:0] val_q;

    // Candidate wins on load or strict greater-than, so ties keep the lower index.
    always_comb begin
        best_idx_c = idx_q;
        best_val_c = val_q;
        if (load || (step && (value > val_q))) begin
            best_idx_c = idx;
            best_val_c = value;
        end
    end

    // Best-so-far register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            val_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            val_q <= '0;
        end else begin
            idx_q <= best_idx_c;
            val_q <= best_val_c;
        end
    end

endmodule

// File: rtl/nn_infer_sequencer.sv
// Inference controller: clear, stream pixel/weight addresses, drain the MAC, argmax, report.
module nn_infer_sequencer
    import nn_pkg::*;
(
    input  logic          pclk,
    input  logic          rst,
    nn_infer_sequencer_if.slave bus
);

    state_t                  state;
    state_t                  state_nxt;
    logic [AW-1:0]           addr;
    logic [AW-1:0]           addr_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [RD_LAT-1:0]       vld_sr;
    logic                    busy_q;
    logic                    done_q;
    logic                    clr_q;
    logic [CW-1:0]           digit_q;
    logic signed [ACC_W-1:0] score_q;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    clr_nxt;
    logic                    am_clear_c;
    logic                    am_load_c;
    logic                    am_step_c;
    logic                    capture_c;
    logic [CW-1:0]           best_idx_c;
    logic signed [ACC_W-1:0] best_val_c;

    // State register.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counters and next values for the registered outputs.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = '0;
        cnt_nxt    = '0;
        am_clear_c = 1'b0;
        am_load_c  = 1'b0;
        am_step_c  = 1'b0;
        capture_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                am_clear_c = 1'b1;
                state_nxt  = STREAM;
            end
            STREAM: begin
                if (addr == AW'(N_PIX - 1)) begin
                    state_nxt = DRAIN;
                end else begin
                    addr_nxt = addr + AW'(1);
                end
            end
            DRAIN: begin
                if (cnt == CW'(DRAIN_CYC - 1)) begin
                    state_nxt = ARGMAX;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ARGMAX: begin
                am_load_c = (cnt == '0);
                am_step_c = (cnt != '0);
                if (cnt == CW'(N_CLS - 1)) begin
                    capture_c = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == CLEAR) || (state_nxt == STREAM) ||
                   (state_nxt == DRAIN) || (state_nxt == ARGMAX);
        clr_nxt  = (state_nxt == CLEAR);
        done_nxt = (state_nxt == DONE);
    end

    // Output registers, counters and the read-latency delay line for acc_en.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            addr    <= '0;
            cnt     <= '0;
            vld_sr  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            digit_q <= '0;
            score_q <= '0;
        end else begin
            addr    <= addr_nxt;
            cnt     <= cnt_nxt;
            vld_sr  <= {vld_sr[RD_LAT-2:0], (state == STREAM)};
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            clr_q   <= clr_nxt;
            if (capture_c) begin
                digit_q <= best_idx_c;
                score_q <= best_val_c;
            end
        end
    end

    nn_argmax_seq u_argmax (
        .clk        (pclk),
        .rst_n      (rst),
        .clear      (am_clear_c),
        .load       (am_load_c),
        .step       (am_step_c),
        .idx        (cnt),
        .value      (acc_slice(bus.acc_sum, cnt)),
        .best_idx_c (best_idx_c),
        .best_val_c (best_val_c)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.acc_clr  = clr_q;
    assign bus.acc_en   = vld_sr[RD_LAT-1];
    assign bus.pix_addr = addr;
    assign bus.w_addr   = addr;
    assign bus.digit    = digit_q;
    assign bus.score    = score_q;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Directed bench for nn_infer_sequencer with a result scoreboard.
// Cycle offsets j count sampling points #1 after each rising edge, j=0 being the
// edge that samples start in IDLE.
module tb_nn_infer_sequencer;
    import nn_pkg::*;

    localparam int LAT = 1 + N_PIX + RD_LAT + MAC_LAT + N_CLS;

    typedef struct packed {
        logic [CW-1:0]    d;
        logic [ACC_W-1:0] s;
    } exp_t;

    logic pclk;
    logic rst;
    nn_infer_sequencer_if bus ();

    nn_infer_sequencer dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int clr_cnt, clr_first, addr_bad, en_cnt, en_first, en_last;
    int overlap, busy_bad, done_cnt, done_j;
    logic [CW-1:0]    got_digit, held_digit;
    logic [ACC_W-1:0] got_score, held_score;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] sums3(input int base, input int k1, input int v1,
                                               input int k2, input int v2);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int k = 0; k < N_CLS; k++) begin
            s[k*ACC_W +: ACC_W] = 32'((k == k1) ? v1 : ((k == k2) ? v2 : base));
        end
        return s;
    endfunction

    task automatic expect_result(input int d, input int s);
        exp_t e;
        e.d = CW'(d);
        e.s = 32'(s);
        sb.push_back(e);
    endtask

    // Raise start for one sampling edge; returns at j=0.
    task automatic kick();
        bus.start = 1'b1;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
    endtask

    // Observe one run for a fixed window, optionally pulsing start at j=glitch_at.
    task automatic watch(input int glitch_at);
        int exp_addr;
        logic exp_busy;
        clr_cnt = 0; clr_first = -1; addr_bad = 0; en_cnt = 0; en_first = -1; en_last = -1;
        overlap = 0; busy_bad = 0; done_cnt = 0; done_j = -1;
        got_digit = 'x; got_score = 'x; held_digit = 'x; held_score = 'x;
        for (int j = 0; j < LAT + 40; j++) begin
            if (j > 0) begin
                @(posedge pclk);
                #1;
            end
            bus.start = (j == glitch_at);
            if (bus.acc_clr) begin
                clr_cnt++;
                if (clr_first < 0) clr_first = j;
            end
            exp_addr = (j >= 1 && j <= N_PIX) ? j - 1 : 0;
            if (bus.pix_addr !== AW'(exp_addr) || bus.w_addr !== AW'(exp_addr)) addr_bad++;
            if (bus.acc_en) begin
                en_cnt++;
                if (en_first < 0) en_first = j;
                en_last = j;
            end
            if (bus.acc_en && bus.acc_clr) overlap++;
            exp_busy = (j < LAT);
            if (bus.busy !== exp_busy) busy_bad++;
            if (bus.done) begin
                done_cnt++;
                if (done_j < 0) begin
                    done_j    = j;
                    got_digit = bus.digit;
                    got_score = bus.score;
                end
            end
            if (done_j >= 0 && j == done_j + 1) begin
                held_digit = bus.digit;
                held_score = bus.score;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_run(input string tag);
        exp_t e;
        chk({tag, " clr_count"}, 64'(clr_cnt), 64'(1));
        chk({tag, " clr_at"}, 64'(clr_first), 64'(0));
        chk({tag, " addr_bad"}, 64'(addr_bad), 64'(0));
        chk({tag, " en_count"}, 64'(en_cnt), 64'(N_PIX));
        chk({tag, " en_first"}, 64'(en_first), 64'(1 + RD_LAT));
        chk({tag, " en_last"}, 64'(en_last), 64'(N_PIX + RD_LAT));
        chk({tag, " en_clr_overlap"}, 64'(overlap), 64'(0));
        chk({tag, " busy_bad"}, 64'(busy_bad), 64'(0));
        chk({tag, " done_count"}, 64'(done_cnt), 64'(1));
        chk({tag, " done_at"}, 64'(done_j), 64'(LAT));
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_nonempty"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, " digit"}, 64'(got_digit), 64'(e.d));
            chk({tag, " score"}, 64'(got_score), 64'(e.s));
            chk({tag, " digit_held"}, 64'(held_digit), 64'(e.d));
            chk({tag, " score_held"}, 64'(held_score), 64'(e.s));
        end
    endtask

    // Directed sequence.
    initial begin
        int h_done;
        int h_clr2;
        int found;
        exp_t e;

        rst = 1'b0;
        bus.start = 1'b0;
        bus.acc_sum = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_outputs", 64'({bus.busy, bus.done, bus.acc_clr, bus.acc_en, bus.pix_addr,
                                  bus.w_addr, bus.digit, bus.score}), 64'(0));
        rst = 1'b1;
        @(posedge pclk);
        #1;

        // Full timing and clear winner.
        bus.acc_sum = sums3(5, 7, 1000, 7, 1000);
        expect_result(7, 1000);
        kick();
        watch(-1);
        check_run("t_class7");

        // Tie between 3 and 8 resolves low.
        bus.acc_sum = sums3(0, 3, 500, 8, 500);
        expect_result(3, 500);
        kick();
        watch(-1);
        check_run("t_tie");

        // All-negative sums need a signed compare.
        bus.acc_sum = sums3(-100, 0, -10, 0, -10);
        expect_result(0, -10);
        kick();
        watch(-1);
        check_run("t_negative");

        // Start pulsed mid-stream is ignored.
        bus.acc_sum = sums3(1, 9, 42, 9, 42);
        expect_result(9, 42);
        kick();
        watch(100);
        check_run("t_glitch");

        // Start held high: back-to-back runs with a one-cycle IDLE gap.
        bus.acc_sum = sums3(-3, 2, 7, 2, 7);
        expect_result(2, 7);
        expect_result(2, 7);
        bus.start = 1'b1;
        @(posedge pclk);
        #1;
        h_done = -1;
        h_clr2 = -1;
        for (int j = 0; j <= LAT + 10 && h_clr2 < 0; j++) begin
            if (j > 0) begin
                @(posedge pclk);
                #1;
            end
            if (bus.done && h_done < 0) begin
                h_done = j;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("t_hold run1 digit", 64'(bus.digit), 64'(e.d));
                    chk("t_hold run1 score", 64'(bus.score), 64'(e.s));
                end
            end
            if (bus.acc_clr && j > 0) h_clr2 = j;
        end
        bus.start = 1'b0;
        chk("t_hold done_at", 64'(h_done), 64'(LAT));
        chk("t_hold clr2_at", 64'(h_clr2), 64'(LAT + 2));
        watch(-1);
        check_run("t_hold run2");

        // Reset in the middle of streaming.
        bus.acc_sum = sums3(0, 4, 9, 4, 9);
        kick();
        found = 0;
        for (int j = 0; j < N_PIX + 10 && found == 0; j++) begin
            @(posedge pclk);
            #1;
            if (bus.pix_addr == AW'(400)) found = 1;
        end
        chk("t_rst reached_addr400", 64'(found), 64'(1));
        chk("t_rst acc_en_before", 64'(bus.acc_en), 64'(1));
        rst = 1'b0;
        #2;
        chk("t_rst busy", 64'(bus.busy), 64'(0));
        chk("t_rst acc_en", 64'(bus.acc_en), 64'(0));
        chk("t_rst acc_clr", 64'(bus.acc_clr), 64'(0));
        chk("t_rst pix_addr", 64'(bus.pix_addr), 64'(0));
        chk("t_rst digit", 64'(bus.digit), 64'(0));
        chk("t_rst score", 64'(bus.score), 64'(0));
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b1;
        @(posedge pclk);
        #1;
        bus.acc_sum = sums3(0, 5, 123456, 1, -5);
        expect_result(5, 123456);
        kick();
        watch(-1);
        check_run("t_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
